// File: rtl/noc_pkt_pkg.sv
// Shared packet layout, ejector FSM encoding and debug view for the mesh local-port sink.
package noc_pkt_pkg;

    localparam int PKTID_W = 10;
    localparam int MODID_W = 6;

    // Packet layout, MSB first: {xDst, yDst, xSrc, ySrc, PacketID, ModuleID}
    localparam int XDST_W    = 4;
    localparam int YDST_W    = 4;
    localparam int XSRC_W    = 4;
    localparam int YSRC_W    = 4;
    localparam int PKTID_LSB = MODID_W;
    localparam int MODID_LSB = 0;
    localparam int YSRC_LSB  = PKTID_LSB + PKTID_W;
    localparam int XSRC_LSB  = YSRC_LSB + YSRC_W;
    localparam int YDST_LSB  = XSRC_LSB + XSRC_W;
    localparam int XDST_LSB  = YDST_LSB + YDST_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } ejState_t;

    typedef struct packed {
        logic [5:0] nodeId;
        ejState_t   state;
        logic [7:0] occupancy;
    } ejDebug_t;

endpackage

// File: rtl/ejector_fifo.sv
// Synchronous FIFO for the packet ejector; push and pop may occur in the same cycle, even when full.
module ejector_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int dataWidth  = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic [dataWidth-1:0]            din,
    output logic [dataWidth-1:0]            dout,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            full,
    output logic                            empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [dataWidth-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rdPtr;
    logic [AW-1:0]        wrPtr;
    logic                 doPush;
    logic                 doPop;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign dout  = mem[rdPtr];

    // A pop in the same cycle frees the head slot, so a full FIFO may still take a push.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/packet_ejector.sv
// Local-port sink of one mesh node: request/grant intake, FIFO buffering, route and sequence checks.
// Optional per-source PacketID sequence check is built when PACKET_EJECTOR_SEQ_CHECK_EN is defined.
module packet_ejector
    import noc_pkt_pkg::*;
#(
    parameter logic [5:0] routerID   = 6'b000_000,
    parameter int         dataWidth  = 32,
    parameter int         dim        = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReqUpStr,
    input  logic [dataWidth-1:0] PacketIn,
    output logic                 GntUpStr,
    output logic                 UpStrFull,
    output logic                 PktValid,
    input  logic                 PktReady,
    output logic [dataWidth-1:0] PktOut,
    output logic [CNT_W-1:0]     RxCount,
    output logic [CNT_W-1:0]     RouteErrCount,
    output logic [CNT_W-1:0]     SeqErrCount,
    output ejDebug_t             ejDebug
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ejState_t       state;
    ejState_t       stateNext;
    logic           gntNext;
    logic           accept;
    logic           pop;
    logic           routeErr;
    logic [CW-1:0]  fifoCount;
    logic           fifoFull;
    logic           fifoEmpty;

    // PE handshake: PktOut is stable while PktValid is high; the head leaves on a cycle with PktValid && PktReady.
    assign PktValid  = !fifoEmpty;
    assign pop       = PktValid && PktReady;
    assign UpStrFull = fifoFull;

    // Residual offset lives in the magnitude bits; the direction bit alone is not an error.
    assign routeErr = (|PacketIn[XDST_LSB +: dim-1]) || (|PacketIn[YDST_LSB +: dim-1]);

    ejector_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .dataWidth  (dataWidth)
    ) uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (PacketIn),
        .dout  (PktOut),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            GntUpStr <= 1'b0;
        end else begin
            state    <= stateNext;
            GntUpStr <= gntNext;
        end
    end

    always_comb begin
        stateNext = state;
        gntNext   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (ReqUpStr && !fifoFull) begin
                    accept    = 1'b1;
                    gntNext   = 1'b1;
                    stateNext = GRANT;
                end
            end
            GRANT:   stateNext = RELEASE;
            // Wait for the router to drop its request so one request is never taken twice.
            RELEASE: if (!ReqUpStr) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RxCount       <= '0;
            RouteErrCount <= '0;
        end else if (accept) begin
            RxCount <= RxCount + CNT_W'(1);
            if (routeErr) RouteErrCount <= RouteErrCount + CNT_W'(1);
        end
    end

`ifdef PACKET_EJECTOR_SEQ_CHECK_EN
    logic [PKTID_W-1:0] lastId [2**MODID_W];
    logic [2**MODID_W-1:0] seen;
    logic [MODID_W-1:0] modId;
    logic [PKTID_W-1:0] pktId;
    logic               seqErr;

    assign modId  = PacketIn[MODID_LSB +: MODID_W];
    assign pktId  = PacketIn[PKTID_LSB +: PKTID_W];
    assign seqErr = seen[modId] && (pktId != lastId[modId] + PKTID_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen        <= '0;
            SeqErrCount <= '0;
        end else if (accept) begin
            seen[modId] <= 1'b1;
            if (seqErr) SeqErrCount <= SeqErrCount + CNT_W'(1);
        end
    end

    // Only the seen bits need clearing; a stale lastId is never consulted.
    always_ff @(posedge clk) begin
        if (accept) lastId[modId] <= pktId;
    end
`else
    assign SeqErrCount = '0;
`endif

    always_comb begin
        ejDebug           = '0;
        ejDebug.nodeId    = routerID;
        ejDebug.state     = state;
        ejDebug.occupancy = 8'(fifoCount);
    end

endmodule

// File: tb/tb_packet_ejector.sv
// Self-checking bench for packet_ejector: queue-based reference model checked every cycle plus directed literals.
module tb_packet_ejector;
    import noc_pkt_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ReqUpStr = 1'b0;
    logic [31:0] PacketIn = '0;
    logic        PktReady = 1'b0;
    logic        GntUpStr;
    logic        UpStrFull;
    logic        PktValid;
    logic [31:0] PktOut;
    logic [15:0] RxCount;
    logic [15:0] RouteErrCount;
    logic [15:0] SeqErrCount;
    ejDebug_t    ejDebug;

    int nCmp = 0;
    int nErr = 0;

    packet_ejector #(
        .routerID   (6'b000_000),
        .dataWidth  (32),
        .dim        (4),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ReqUpStr      (ReqUpStr),
        .PacketIn      (PacketIn),
        .GntUpStr      (GntUpStr),
        .UpStrFull     (UpStrFull),
        .PktValid      (PktValid),
        .PktReady      (PktReady),
        .PktOut        (PktOut),
        .RxCount       (RxCount),
        .RouteErrCount (RouteErrCount),
        .SeqErrCount   (SeqErrCount),
        .ejDebug       (ejDebug)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packets accepted are those requested while fewer than DEPTH are held,
    // provided the request was seen low at least two edges after the previous accept.
    logic [31:0] expQ[$];
    logic [15:0] mRx, mRoute, mSeq;
    bit          mGnt;
    bit          hasAcc;
    int          edgeNo, lastAcc, lastLow;
    int          mLastId [64];
    bit          mSeen [64];
    bit          acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            expQ.delete();
            mRx = 0; mRoute = 0; mSeq = 0;
            mGnt = 0; hasAcc = 0;
            for (int i = 0; i < 64; i++) mSeen[i] = 0;
        end else begin
            edgeNo++;
            acc = ReqUpStr && (expQ.size() < DEPTH) && (!hasAcc || lastLow >= lastAcc + 2);
            if (!ReqUpStr) lastLow = edgeNo;
            if (expQ.size() > 0 && PktReady) void'(expQ.pop_front());
            if (acc) begin
                expQ.push_back(PacketIn);
                mRx++;
                if (PacketIn[30:28] != 0 || PacketIn[26:24] != 0) mRoute++;
`ifdef PACKET_EJECTOR_SEQ_CHECK_EN
                if (mSeen[PacketIn[5:0]] && int'(PacketIn[15:6]) != (mLastId[PacketIn[5:0]] + 1) % 1024)
                    mSeq++;
`endif
                mLastId[PacketIn[5:0]] = int'(PacketIn[15:6]);
                mSeen[PacketIn[5:0]] = 1;
                lastAcc = edgeNo;
                hasAcc = 1;
            end
            mGnt = acc;
        end
    end

    always @(negedge clk) begin
        chk("gnt", 32'(GntUpStr), 32'(mGnt));
        chk("valid", 32'(PktValid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) chk("pktout", PktOut, expQ[0]);
        chk("full", 32'(UpStrFull), 32'(expQ.size() == DEPTH));
        chk("occupancy", 32'(ejDebug.occupancy), 32'(expQ.size()));
        chk("rxcount", 32'(RxCount), 32'(mRx));
        chk("routeerr", 32'(RouteErrCount), 32'(mRoute));
        chk("seqerr", 32'(SeqErrCount), 32'(mSeq));
    end

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1; ReqUpStr = 1'b0; PktReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic raiseReq(input logic [31:0] pkt, input int limit, output bit granted);
        @(posedge clk); #1;
        PacketIn = pkt; ReqUpStr = 1'b1; granted = 0;
        for (int i = 0; i < limit && !granted; i++) begin
            @(negedge clk);
            if (GntUpStr) granted = 1;
        end
    endtask

    task automatic dropReq();
        @(posedge clk); #1 ReqUpStr = 1'b0;
    endtask

    task automatic sendPkt(input logic [31:0] pkt);
        bit g;
        raiseReq(pkt, 6, g);
        chk("send_granted", 32'(g), 32'd1);
        dropReq();
    endtask

    initial begin
        bit g;
        int grants;
        logic [15:0] expSeq;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(GntUpStr), 32'd0);
        chk("rst_valid", 32'(PktValid), 32'd0);
        chk("rst_full", 32'(UpStrFull), 32'd0);
        chk("rst_rx", 32'(RxCount), 32'd0);
        chk("rst_state", 32'(ejDebug.state), 32'(IDLE));
        chk("rst_node", 32'(ejDebug.nodeId), 32'd0);
        #1 reset = 1'b0;

        // Single request
        raiseReq(32'h0000_0405, 6, g);
        chk("t1_granted", 32'(g), 32'd1);
        chk("t1_gnt", 32'(GntUpStr), 32'd1);
        chk("t1_pktout", PktOut, 32'h0000_0405);
        chk("t1_valid", 32'(PktValid), 32'd1);
        chk("t1_rx", 32'(RxCount), 32'd1);
        chk("t1_route", 32'(RouteErrCount), 32'd0);
        dropReq();
        @(negedge clk);
        chk("t1_gnt_once", 32'(GntUpStr), 32'd0);

        // Request held high for 6 cycles
        doReset();
        @(posedge clk); #1;
        PacketIn = 32'h0000_0081; ReqUpStr = 1'b1; grants = 0;
        repeat (6) begin
            @(negedge clk);
            if (GntUpStr) grants++;
        end
        dropReq();
        @(negedge clk);
        chk("t2_grants", 32'(grants), 32'd1);
        chk("t2_rx", 32'(RxCount), 32'd1);

        // Fill the FIFO, fifth request waits for a pop
        doReset();
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            raiseReq({16'h0, 10'(k + 1), 6'd1}, 6, g);
            if (g) grants++;
            dropReq();
        end
        raiseReq({16'h0, 10'd5, 6'd1}, 4, g);
        chk("t3_grants", 32'(grants), 32'd4);
        chk("t3_fifth_blocked", 32'(g), 32'd0);
        chk("t3_full", 32'(UpStrFull), 32'd1);
        @(posedge clk); #1 PktReady = 1'b1;
        @(posedge clk); #1 PktReady = 1'b0;
        g = 0;
        for (int i = 0; i < 6 && !g; i++) begin
            @(negedge clk);
            if (GntUpStr) g = 1;
        end
        chk("t3_fifth_granted", 32'(g), 32'd1);
        dropReq();
        @(negedge clk);
        chk("t3_rx", 32'(RxCount), 32'd5);

        // Residual route offset
        doReset();
        raiseReq(32'h2000_01C2, 6, g);
        chk("t4_route", 32'(RouteErrCount), 32'd1);
        chk("t4_pktout", PktOut, 32'h2000_01C2);
        dropReq();
        sendPkt(32'h0800_0042);
        @(negedge clk);
        chk("t4_dir_only", 32'(RouteErrCount), 32'd1);

        // Sequence check
        doReset();
        PktReady = 1'b1;
        sendPkt({16'h0, 10'd1, 6'd3});
        sendPkt({16'h0, 10'd2, 6'd3});
        sendPkt({16'h0, 10'd4, 6'd3});
        sendPkt({16'h0, 10'd5, 6'd3});
        sendPkt({16'h0, 10'd1023, 6'd7});
        sendPkt({16'h0, 10'd0, 6'd7});
        @(negedge clk);
`ifdef PACKET_EJECTOR_SEQ_CHECK_EN
        expSeq = 16'd1;
`else
        expSeq = 16'd0;
`endif
        chk("t5_seq", 32'(SeqErrCount), 32'(expSeq));
        chk("t5_rx", 32'(RxCount), 32'd6);

        // Reset while in GRANT with two entries held
        doReset();
        sendPkt(32'h0000_0101);
        raiseReq(32'h0000_0142, 6, g);
        chk("t6_granted", 32'(g), 32'd1);
        chk("t6_two_held", 32'(ejDebug.occupancy), 32'd2);
        #1 reset = 1'b1; ReqUpStr = 1'b0;
        #1;
        chk("t6_gnt", 32'(GntUpStr), 32'd0);
        chk("t6_valid", 32'(PktValid), 32'd0);
        chk("t6_rx", 32'(RxCount), 32'd0);
        chk("t6_route", 32'(RouteErrCount), 32'd0);
        chk("t6_seq", 32'(SeqErrCount), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        nErr++;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/packet_ejector.md
# packet_ejector

Local-port sink for one mesh node: the receiving end of the router's local output. It accepts 32-bit packets from the router with a request/grant handshake, buffers them in a small FIFO, and checks that each arrived with zero residual X/Y offset. It optionally checks per-source PacketID sequence, keeps receive and error counters, and presents packets to the local PE with a valid/ready interface.

## Interface
Parameters:
- routerID, 6'b000_000, node this ejector sits on (reported only).
- dataWidth, 32, packet width.
- dim, 4, width of each X/Y field: 1 direction bit plus 3 magnitude bits.
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2.
- CNT_W, 16, width of statistic counters.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- ReqUpStr, input, 1, router requests transfer; PacketIn is valid while high.
- PacketIn, input, dataWidth, packet {xDst, yDst, xSrc, ySrc, PacketID[9:0], ModuleID[5:0]}.
- GntUpStr, output, 1, registered one-cycle grant.
- UpStrFull, output, 1, FIFO full indicator to the router.
- PktValid, output, 1, FIFO head valid toward the PE.
- PktReady, input, 1, PE accepts the head.
- PktOut, output, dataWidth, FIFO head.
- RxCount, output, CNT_W, packets accepted.
- RouteErrCount, output, CNT_W, packets with nonzero residual offset.
- SeqErrCount, output, CNT_W, sequence violations. Tied to 0 when the feature is compiled out.

## Operation
- Reset values: every output and counter is 0, the FSM is in IDLE, and the FIFO is empty.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if ReqUpStr and the FIFO is not full at this edge, capture PacketIn, push it to the FIFO, set GntUpStr to 1, and go to GRANT. If the FIFO is full, stay in IDLE with no grant.
- GRANT: GntUpStr goes to 0 and the FSM moves to RELEASE unconditionally.
- RELEASE: stay until ReqUpStr is sampled low, then go to IDLE. This prevents double-accepting a request the router has not yet dropped.
- Route check runs on each accepted packet. If xDst[2:0] or yDst[2:0] is nonzero, RouteErrCount increments. The packet is still buffered.
- Counters wrap modulo 2^CNT_W. RxCount increments once per grant.
- PE side: PktValid equals FIFO not empty, and PktOut equals the head. A pop happens when PktValid and PktReady are both high.
- Push and pop in the same cycle are both allowed, including when the FIFO is full. The full check uses the pre-edge count, so a full FIFO does not grant even if a pop happens that cycle.
- UpStrFull is high when count equals FIFO_DEPTH. It is registered from the post-edge count.
- A reset mid-transfer drops the grant immediately, empties the FIFO, and clears the counters.

## Timing
- A request sampled high at edge N while not full gives GntUpStr high for cycle N+1 and data in the FIFO after edge N.
- PktValid goes high in cycle N+1.
- Maximum accept rate is one packet per 3 cycles: IDLE, GRANT, RELEASE with the request already low.
- UpStrFull asserts in the cycle after the push that fills the FIFO, and deasserts in the cycle after the pop that frees an entry.
- Empty FIFO latency from accept to PktValid is 1 cycle.

## Configuration
- Macro: PACKET_EJECTOR_SEQ_CHECK_EN.
- Defined: a 64-entry table, indexed by ModuleID, holds the last PacketID plus a seen bit.
  - On accept of a seen source, if PacketID is not last+1 (mod 1024), SeqErrCount increments.
  - The table entry is then updated and the seen bit set.
  - Reset clears all seen bits.
- Undefined: no table, and SeqErrCount is constant 0.

## Structure
- Shared package noc_pkt_pkg holds:
  - field offsets and widths: XDST, YDST, XSRC, YSRC, PKTID, MODID;
  - the IDLE/GRANT/RELEASE encoding;
  - the PKTID_W=10 and MODID_W=6 constants.
- Sub-module ejector_fifo, a synchronous FIFO with parameters FIFO_DEPTH and dataWidth.
  - Inputs: push, pop, din.
  - Outputs: dout, count, full, empty.
  - It allows simultaneous push and pop.

## Test plan
- Reset, then a single request with PacketIn=32'h0000_0405 → GntUpStr high exactly 1 cycle, PktOut=32'h0000_0405, PktValid=1, RxCount=1, RouteErrCount=0.
- ReqUpStr held high for 6 cycles → exactly one grant, and RxCount=1.
- PktReady=0 with 5 back-to-back requests at FIFO_DEPTH=4 → 4 grants, UpStrFull=1, 5th request gets no grant; raise PktReady for 1 cycle → 5th granted next IDLE, RxCount=5.
- Packet with xDst=4'b0_010 → RouteErrCount=1, packet still delivered on PktOut.
- With PACKET_EJECTOR_SEQ_CHECK_EN and ModuleID=3, PacketIDs 1, 2, 4, 5 → SeqErrCount=1. PacketID 1023 followed by 0 → no error.
- Assert reset while the FSM is in GRANT with 2 entries buffered → GntUpStr=0, PktValid=0, all counters 0 in the same cycle.
